wb_arbiter_n: RTL and testbench
===============================

# wb_arbiter_n

Parametrised N-master pipelined Wishbone arbiter: the next generation of the two-port bus controller between instruction/data master ports and the single memory bus. Grants one master at a time onto one slave bus, holds the grant for the master's whole cycle, tracks outstanding pipelined requests, and routes acks and read data back. It sits between the fetch/mem stage master ports (plus any DMA or debug masters) and the RAM/bus-fabric slave.

## Interface
- NMASTERS, 2: master port count (2..8); index 0 = instruction port.
- AW, 32: address width.
- DW, 32: data width (multiple of 8); SW = DW/8 select width.
- MAXOUT, 4: max outstanding (accepted, un-acked) requests; power of two.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- m_cyc_i  in  NMASTERS  per-master cyc
- m_stb_i  in  NMASTERS  per-master stb
- m_we_i  in  NMASTERS  per-master we
- m_sel_i  in  NMASTERS*SW  packed sel, master i at [i*SW +: SW]
- m_adr_i  in  NMASTERS*AW  packed address
- m_dat_i  in  NMASTERS*DW  packed write data (dat_m)
- m_dat_o  out  DW  read data (dat_s), broadcast to all masters
- m_ack_o  out  NMASTERS  per-master ack
- m_stall_o  out  NMASTERS  per-master stall
- s_cyc_o, s_stb_o, s_we_o  out  1  slave cyc/stb/we
- s_sel_o  out  SW;  s_adr_o  out  AW;  s_dat_o  out  DW  slave request fields
- s_dat_i  in  DW;  s_ack_i  in  1;  s_stall_i  in  1  slave response
- grant_o  out  $clog2(NMASTERS) (min 1)  current grant index, debug/trace

## Operation
- States: IDLE, BUSY.
- IDLE: all m_stall_o=1, s_cyc_o=s_stb_o=0. Any m_cyc_i high -> winner registered into grant, go BUSY.
- BUSY: s_cyc_o=m_cyc_i[grant]; s_stb_o=m_stb_i[grant] & ~full; we/sel/adr/dat muxed from grant. m_stall_o[grant]=s_stall_i|full; all other m_stall_o=1.
- Accept = s_stb_o & ~s_stall_i. outstanding: +1 on accept, -1 on s_ack_i, unchanged when both. full = (outstanding==MAXOUT).
- s_ack_i routed to m_ack_o[grant] only; m_dat_o = s_dat_i combinationally.
- BUSY -> IDLE when m_cyc_i[grant]=0. Master dropping cyc with outstanding>0 is an abort: outstanding cleared to 0, late s_ack_i in IDLE is discarded (no m_ack_o).
- s_ack_i with outstanding==0 in BUSY: passed to the granted master, counter saturates at 0.
- last register holds the most recently granted index, used for round-robin.

## Timing
- Reset: state IDLE, grant=0, last=NMASTERS-1, outstanding=0; s_cyc_o=s_stb_o=0, m_ack_o=0, m_stall_o all 1, grant_o=0.
- Request latency: m_cyc_i rises cycle N -> s_cyc_o/s_stb_o at N+1 (one arbitration cycle); zero-latency pass-through thereafter.
- Release: m_cyc_i[grant] low at N -> IDLE at N+1; new grant at N+2 earliest. No back-to-back grant without an IDLE cycle.
- Ack: zero-cycle, combinational from s_ack_i.
- Reset asserted mid-cycle: all state cleared immediately; outputs go to reset values asynchronously.

## Configuration
- WB_ARBITER_RR_EN defined: round-robin; search starts at last+1, wraps modulo NMASTERS.
- Undefined: fixed priority, lowest index wins (instruction port 0 highest); last register unused.

## Structure
- Shared package (bexkat1 package): arbiter state enum, MAXOUT default, packed-port slice helper function.
- One sub-module: wb_arb_pick (combinational priority/rotating picker: request vector + last -> index + valid), reused by the interrupt controller.

## Test plan
- Single master 1 issues 3 pipelined reads to 0x100,0x104,0x108, slave acks each after 2 cycles -> grant_o=1, s_cyc_o at N+1, three m_ack_o[1] with s_dat_i data, IDLE one cycle after cyc drop.
- Masters 0 and 1 request simultaneously, repeated 4 cycles each: RR build grants 0,1,0,1; non-RR grants 0,0,0,0 while 0 keeps requesting.
- MAXOUT=4, slave never acks for 6 stb cycles -> exactly 4 accepts, s_stb_o=0 and m_stall_o[grant]=1 from 5th; one ack -> one more accept.
- Master 1 drops cyc with 2 outstanding, slave acks 2 cycles later -> no m_ack_o, outstanding=0, master 0 grant proceeds cleanly.
- s_stall_i held 3 cycles during write 0xDEADBEEF to 0x200 sel=4'hF -> s_adr_o/s_dat_o stable, single accept, one ack.
- rst_i pulsed while BUSY with 2 outstanding -> all outputs reset values same cycle, grant_o=0, next request re-arbitrated.

Source files
------------

// File: rtl/wb_arbiter_n_pkg.sv
// Shared definitions for the N-master pipelined Wishbone arbiter.
package wb_arbiter_n_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   localparam int unsigned MAXOUT_DEFAULT = 4;

   // Low bit of field idx inside a packed per-master port of element width w.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Master-side and slave-side bus signals of the arbiter, seen from the arbiter.
interface wb_arbiter_n_if #(
   parameter int unsigned NMASTERS = 2,
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32
);
   localparam int unsigned SW = DW / 8;
   localparam int unsigned GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

   logic [NMASTERS-1:0]    m_cyc_i;
   logic [NMASTERS-1:0]    m_stb_i;
   logic [NMASTERS-1:0]    m_we_i;
   logic [NMASTERS*SW-1:0] m_sel_i;
   logic [NMASTERS*AW-1:0] m_adr_i;
   logic [NMASTERS*DW-1:0] m_dat_i;
   logic [DW-1:0]          m_dat_o;
   logic [NMASTERS-1:0]    m_ack_o;
   logic [NMASTERS-1:0]    m_stall_o;
   logic [GW-1:0]          grant_o;

   logic                   s_cyc_o;
   logic                   s_stb_o;
   logic                   s_we_o;
   logic [SW-1:0]          s_sel_o;
   logic [AW-1:0]          s_adr_o;
   logic [DW-1:0]          s_dat_o;
   logic [DW-1:0]          s_dat_i;
   logic                   s_ack_i;
   logic                   s_stall_i;

   // Arbiter port facing the upstream masters
   modport master (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output m_dat_o, m_ack_o, m_stall_o, grant_o
   );

   // Arbiter port facing the downstream slave
   modport slave (
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i, s_stall_i
   );
endinterface

// File: rtl/wb_arb_pick.sv
// Combinational request picker: fixed priority (lowest index) or rotating
// priority starting just after the last winner. Shared with the interrupt
// controller.
module wb_arb_pick #(
   parameter int unsigned N  = 2,
   parameter bit          RR = 1'b0,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan candidates in priority order and keep the first requester
   always_comb begin
      int unsigned   start;
      logic [IW-1:0] pos;
      logic          found;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      start = RR ? (32'(last) + 32'd1) : 32'd0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = IW'((start + k) % N);
         if (!found && req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
      valid = |req;
   end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master pipelined Wishbone arbiter with outstanding-request tracking.
// Build option: WB_ARBITER_RR_EN selects round-robin arbitration; without it
// the lowest master index wins.
module wb_arbiter_n
   import wb_arbiter_n_pkg::*;
#(
   parameter int unsigned NMASTERS = 2,
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAXOUT   = MAXOUT_DEFAULT
) (
   input  logic           clk_i,
   input  logic           rst_i,
   wb_arbiter_n_if.master mp,
   wb_arbiter_n_if.slave  sp
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
   localparam int unsigned OW = $clog2(MAXOUT) + 1;

`ifdef WB_ARBITER_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   arb_state_t    state;
   arb_state_t    state_next;
   logic [GW-1:0] grant;
   logic [GW-1:0] last;
   logic [GW-1:0] pick_idx;
   logic          pick_valid;
   logic          cyc_g;
   logic          stb_g;
   logic          full;
   logic          accept;
   logic [OW-1:0] outstanding;

   wb_arb_pick #(
      .N  (NMASTERS),
      .RR (RR_EN)
   ) u_pick (
      .req   (mp.m_cyc_i),
      .last  (last),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // cyc/stb of the currently granted master
   always_comb begin
      cyc_g = 1'b0;
      stb_g = 1'b0;
      for (int unsigned i = 0; i < NMASTERS; i++) begin
         if (grant == GW'(i)) begin
            cyc_g = mp.m_cyc_i[i];
            stb_g = mp.m_stb_i[i];
         end
      end
   end

   assign full   = (outstanding == OW'(MAXOUT));
   assign accept = (state == ST_BUSY) & stb_g & ~full & ~sp.s_stall_i;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next state: arbitrate in IDLE, hold grant until the owner drops cyc
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (pick_valid) state_next = ST_BUSY;
         ST_BUSY: if (!cyc_g)     state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   // Grant and round-robin history, loaded only on an arbitration win
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         grant <= '0;
         last  <= GW'(NMASTERS - 1);
      end else if (state == ST_IDLE && pick_valid) begin
         grant <= pick_idx;
         last  <= pick_idx;
      end
   end

   // Outstanding request count; cleared outside a cycle so late acks vanish
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else if (state != ST_BUSY || !cyc_g) begin
         outstanding <= '0;
      end else if (accept && !sp.s_ack_i) begin
         outstanding <= outstanding + OW'(1);
      end else if (!accept && sp.s_ack_i && outstanding != '0) begin
         outstanding <= outstanding - OW'(1);
      end
   end

   // Outputs: route the granted master to the slave and responses back
   always_comb begin
      mp.m_stall_o = '1;
      mp.m_ack_o   = '0;
      sp.s_cyc_o   = 1'b0;
      sp.s_stb_o   = 1'b0;
      sp.s_we_o    = 1'b0;
      sp.s_sel_o   = '0;
      sp.s_adr_o   = '0;
      sp.s_dat_o   = '0;
      case (state)
         ST_BUSY: begin
            sp.s_cyc_o = cyc_g;
            sp.s_stb_o = stb_g & ~full;
            for (int unsigned i = 0; i < NMASTERS; i++) begin
               if (grant == GW'(i)) begin
                  sp.s_we_o       = mp.m_we_i[i];
                  sp.s_sel_o      = mp.m_sel_i[slice_lo(i, SW) +: SW];
                  sp.s_adr_o      = mp.m_adr_i[slice_lo(i, AW) +: AW];
                  sp.s_dat_o      = mp.m_dat_i[slice_lo(i, DW) +: DW];
                  mp.m_stall_o[i] = sp.s_stall_i | full;
                  mp.m_ack_o[i]   = sp.s_ack_i;
               end
            end
         end
         default: ;
      endcase
   end

   assign mp.m_dat_o = sp.s_dat_i;
   assign mp.grant_o = grant;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: directed scenarios then random traffic, all
// checked against a cycle-level owner/pending-count model.
module tb_wb_arbiter_n;

   localparam int unsigned NM     = 3;
   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned SW     = DW / 8;
   localparam int          MAXOUT = 4;

`ifdef WB_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst;

   wb_arbiter_n_if #(.NMASTERS(NM), .AW(AW), .DW(DW)) bus ();

   wb_arbiter_n #(
      .NMASTERS (NM),
      .AW       (AW),
      .DW       (DW),
      .MAXOUT   (MAXOUT)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .mp    (bus),
      .sp    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // model: who owns the bus, how many requests are pending
   bit own_v;
   int own;
   int pend;
   int last_m;
   int gexp;

   // bench-side slave and observation counters
   int cyc_no;
   int due_q[$];
   bit slave_auto;
   int slave_lat;
   int n_accept;
   int n_ack[NM];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NM-1:0] req);
      int start;
      start = RR ? last_m + 1 : 0;
      for (int k = 0; k < int'(NM); k++) begin
         if (req[(start + k) % NM]) return (start + k) % NM;
      end
      return -1;
   endfunction

   task automatic model_reset();
      own_v  = 1'b0;
      own    = 0;
      pend   = 0;
      last_m = NM - 1;
      gexp   = 0;
   endtask

   task automatic set_m(input int i, input bit c, input bit s, input bit w,
                        input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat);
      bus.m_cyc_i[i]            = c;
      bus.m_stb_i[i]            = s;
      bus.m_we_i[i]             = w;
      bus.m_sel_i[i*SW +: SW]   = sel;
      bus.m_adr_i[i*AW +: AW]   = adr;
      bus.m_dat_i[i*DW +: DW]   = dat;
   endtask

   task automatic clear_all();
      bus.m_cyc_i   = '0;
      bus.m_stb_i   = '0;
      bus.m_we_i    = '0;
      bus.m_sel_i   = '0;
      bus.m_adr_i   = '0;
      bus.m_dat_i   = '0;
      bus.s_ack_i   = 1'b0;
      bus.s_stall_i = 1'b0;
      bus.s_dat_i   = $urandom;
      due_q.delete();
   endtask

   // One clock: check outputs at negedge, advance model, step past posedge
   task automatic step();
      logic [NM-1:0] e_stall;
      logic [NM-1:0] e_ack;
      logic          e_cyc;
      logic          e_stb;
      logic          e_full;
      int            w;
      @(negedge clk);
      e_stall = '1;
      e_ack   = '0;
      e_cyc   = 1'b0;
      e_stb   = 1'b0;
      e_full  = (pend == MAXOUT);
      if (own_v) begin
         e_cyc        = bus.m_cyc_i[own];
         e_stb        = bus.m_stb_i[own] && !e_full;
         e_stall[own] = bus.s_stall_i || e_full;
         e_ack[own]   = bus.s_ack_i;
      end
      chk("s_cyc",   64'(bus.s_cyc_o),   64'(e_cyc));
      chk("s_stb",   64'(bus.s_stb_o),   64'(e_stb));
      chk("m_stall", 64'(bus.m_stall_o), 64'(e_stall));
      chk("m_ack",   64'(bus.m_ack_o),   64'(e_ack));
      chk("m_dat",   64'(bus.m_dat_o),   64'(bus.s_dat_i));
      chk("grant",   64'(bus.grant_o),   64'(gexp));
      if (own_v && e_cyc) begin
         chk("s_we",  64'(bus.s_we_o),  64'(bus.m_we_i[own]));
         chk("s_sel", 64'(bus.s_sel_o), 64'(bus.m_sel_i[own*SW +: SW]));
         chk("s_adr", 64'(bus.s_adr_o), 64'(bus.m_adr_i[own*AW +: AW]));
         chk("s_dat", 64'(bus.s_dat_o), 64'(bus.m_dat_i[own*DW +: DW]));
      end
      if (bus.s_stb_o && !bus.s_stall_i) begin
         n_accept++;
         if (slave_auto) due_q.push_back(cyc_no + slave_lat);
      end
      for (int i = 0; i < int'(NM); i++) if (bus.m_ack_o[i]) n_ack[i]++;
      if (!own_v) begin
         pend = 0;
         w = pick(bus.m_cyc_i);
         if (w >= 0) begin
            own_v  = 1'b1;
            own    = w;
            last_m = w;
            gexp   = w;
         end
      end else if (!bus.m_cyc_i[own]) begin
         own_v = 1'b0;
         pend  = 0;
      end else begin
         if (e_stb && !bus.s_stall_i && !bus.s_ack_i) pend++;
         else if (!(e_stb && !bus.s_stall_i) && bus.s_ack_i && pend > 0) pend--;
      end
      @(posedge clk);
      #1;
      cyc_no++;
      if (slave_auto) begin
         bus.s_ack_i = 1'b0;
         if (due_q.size() > 0 && due_q[0] == cyc_no) begin
            bus.s_ack_i = 1'b1;
            void'(due_q.pop_front());
         end
      end
      bus.s_dat_i = $urandom;
   endtask

   initial begin
      int exp_g [4];
      rst        = 1'b1;
      cyc_no     = 0;
      slave_auto = 1'b0;
      slave_lat  = 2;
      n_accept   = 0;
      for (int i = 0; i < int'(NM); i++) n_ack[i] = 0;
      clear_all();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_cyc",   64'(bus.s_cyc_o),   64'(0));
      chk("rst_s_stb",   64'(bus.s_stb_o),   64'(0));
      chk("rst_m_stall", 64'(bus.m_stall_o), 64'(3'b111));
      chk("rst_m_ack",   64'(bus.m_ack_o),   64'(0));
      chk("rst_grant",   64'(bus.grant_o),   64'(0));
      rst = 1'b0;

      // 1: master 1 issues three pipelined reads, slave acks after 2 cycles
      slave_auto = 1'b1;
      slave_lat  = 2;
      set_m(1, 1, 1, 0, 4'hF, 32'h100, 32'h0);
      step();
      chk("s1_grant", 64'(bus.grant_o), 64'(1));
      step();
      set_m(1, 1, 1, 0, 4'hF, 32'h104, 32'h0);
      step();
      set_m(1, 1, 1, 0, 4'hF, 32'h108, 32'h0);
      step();
      set_m(1, 1, 0, 0, 4'hF, 32'h108, 32'h0);
      repeat (3) step();
      set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      step();
      chk("s1_acks_m1", 64'(n_ack[1]), 64'(3));

      // 2: masters 0 and 1 compete in four back-to-back cycles
      slave_auto = 1'b0;
      clear_all();
      exp_g = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
      for (int r = 0; r < 4; r++) begin
         set_m(0, 1, 1, 0, 4'hF, 32'h1000 + 32'(r), 32'h0);
         set_m(1, 1, 1, 0, 4'hF, 32'h2000 + 32'(r), 32'h0);
         step();
         chk("s2_grant", 64'(bus.grant_o), 64'(exp_g[r]));
         step();
         set_m(exp_g[r], 0, 0, 0, 4'h0, 32'h0, 32'h0);
         step();
      end
      clear_all();
      step();

      // 3: slave never acks, accepts stop at the outstanding limit
      n_accept = 0;
      set_m(0, 1, 1, 0, 4'hF, 32'h300, 32'h0);
      step();
      repeat (6) step();
      chk("s3_accepts_full", 64'(n_accept), 64'(MAXOUT));
      bus.s_ack_i = 1'b1;
      step();
      bus.s_ack_i = 1'b0;
      step();
      chk("s3_accepts_after_ack", 64'(n_accept), 64'(MAXOUT + 1));
      clear_all();
      step();
      step();

      // 4: master 1 aborts with two outstanding, late acks are dropped
      slave_auto = 1'b1;
      slave_lat  = 3;
      n_ack[0]   = 0;
      n_ack[1]   = 0;
      set_m(1, 1, 1, 0, 4'hF, 32'h400, 32'h0);
      step();
      step();
      step();
      set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      repeat (4) step();
      chk("s4_abort_acks", 64'(n_ack[1]), 64'(0));
      slave_lat = 1;
      set_m(0, 1, 1, 0, 4'hF, 32'h500, 32'h0);
      step();
      step();
      set_m(0, 1, 0, 0, 4'hF, 32'h500, 32'h0);
      step();
      step();
      set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      chk("s4_m0_acks", 64'(n_ack[0]), 64'(1));

      // 5: stalled write holds its fields until accepted
      n_accept = 0;
      n_ack[0] = 0;
      set_m(0, 1, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF);
      bus.s_stall_i = 1'b1;
      step();
      repeat (3) step();
      bus.s_stall_i = 1'b0;
      step();
      set_m(0, 1, 0, 1, 4'hF, 32'h200, 32'hDEADBEEF);
      step();
      step();
      chk("s5_accepts", 64'(n_accept), 64'(1));
      chk("s5_acks",    64'(n_ack[0]), 64'(1));
      set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      step();

      // 6: reset while busy with two outstanding
      slave_auto = 1'b0;
      clear_all();
      set_m(1, 1, 1, 0, 4'hF, 32'h600, 32'h0);
      step();
      step();
      step();
      rst         = 1'b1;
      bus.s_ack_i = 1'b1;
      #1;
      model_reset();
      chk("s6_s_cyc",   64'(bus.s_cyc_o),   64'(0));
      chk("s6_s_stb",   64'(bus.s_stb_o),   64'(0));
      chk("s6_m_stall", 64'(bus.m_stall_o), 64'(3'b111));
      chk("s6_m_ack",   64'(bus.m_ack_o),   64'(0));
      chk("s6_grant",   64'(bus.grant_o),   64'(0));
      #2;
      rst         = 1'b0;
      bus.s_ack_i = 1'b0;
      step();
      chk("s6_regrant", 64'(bus.grant_o), 64'(1));
      step();
      clear_all();
      step();
      step();

      // 7: random traffic from all masters against a random slave
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < int'(NM); i++) begin
            logic cy;
            cy = bus.m_cyc_i[i];
            if ($urandom_range(5) == 0) cy = ~cy;
            set_m(i, cy, $urandom_range(9) < 7, 1'($urandom), 4'($urandom),
                  $urandom, $urandom);
         end
         bus.s_ack_i   = ($urandom_range(3) == 0);
         bus.s_stall_i = ($urandom_range(3) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
